// File: rtl/hls_seq_pkg.sv
// Shared definitions for the microcoded HLS control sequencer:
// control-word field layout, reg_en bit indices, FSM states and opcodes.
package hls_seq_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 4;

  // Control-word field offsets and widths
  localparam int unsigned ALU1_SEL1_LSB = 0;
  localparam int unsigned ALU1_SEL2_LSB = 4;
  localparam int unsigned ALU1_OP_BIT   = 8;
  localparam int unsigned MUL1_SEL1_LSB = 9;
  localparam int unsigned MUL1_SEL2_LSB = 13;
  localparam int unsigned MUL1_OP_BIT   = 17;
  localparam int unsigned REG_EN_LSB    = 18;
  localparam int unsigned REG_EN_W      = 7;
  localparam int unsigned RESULT_EN_BIT = 25;
  localparam int unsigned RSVD_LSB      = 26;
  localparam int unsigned RSVD_W        = 2;
  localparam int unsigned HOLD_LSB      = 28;
  localparam int unsigned HOLD_W        = 3;
  localparam int unsigned LAST_BIT      = 31;

  // reg_en bit indices into the datapath register bank
  localparam int unsigned REG_MUL2  = 0;
  localparam int unsigned REG_MUL4  = 1;
  localparam int unsigned REG_MUL6  = 2;
  localparam int unsigned REG_MUL9  = 3;
  localparam int unsigned REG_MUL11 = 4;
  localparam int unsigned REG_MUL13 = 5;
  localparam int unsigned REG_ALU14 = 6;

  // Functional-unit opcodes
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } seq_state_e;

endpackage

// File: rtl/hls_seq_prog_mem.sv
// Program store for the sequencer: DEPTH x 32 bits, one synchronous write
// port and one asynchronous read port. Contents are never reset.
module hls_seq_prog_mem #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hls_sequencer.sv
// Microcoded control sequencer for the shared-FU datapath. Steps through a
// writable program of 32-bit control words, one per cycle after start.
// Optional feature macro: HLS_SEQ_HOLD_EN enables the per-word hold field
// so a word can be repeated for multi-cycle operations such as DIV.
module hls_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned START_PC = 0,
  localparam int unsigned PC_W    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_wdata,
  output logic [3:0]      alu1_sel1,
  output logic [3:0]      alu1_sel2,
  output logic [3:0]      mul1_sel1,
  output logic [3:0]      mul1_sel2,
  output logic            alu1_op,
  output logic            mul1_op,
  output logic [6:0]      reg_en,
  output logic            result_en,
  output logic            done_next
);

  import hls_seq_pkg::*;

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     word;
  logic            hold_more;
  logic            at_end;

  // Program writes are locked out while a run is in progress
  hls_seq_prog_mem #(
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state_q == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc_q),
    .rdata (word)
  );

`ifdef HLS_SEQ_HOLD_EN
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;

  assign hold_more = (word[HOLD_LSB +: HOLD_W] > hcnt_q);

  // Hold counter: cycles already spent on the current word
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`else
  assign hold_more = 1'b0;
`endif

  // Reserved bits (and hold when the feature is off) are deliberately ignored
  logic unused_word;
  assign unused_word = ^{word[RSVD_LSB +: RSVD_W], word[HOLD_LSB +: HOLD_W]};

  // No wrap-around: the last physical word always terminates the run
  assign at_end = word[LAST_BIT] || (pc_q == PC_W'(DEPTH - 1));
  assign busy   = (state_q == RUN);

  // State and program counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(START_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic and control-word decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
`ifdef HLS_SEQ_HOLD_EN
    hcnt_d    = hcnt_q;
`endif
    alu1_sel1 = '0;
    alu1_sel2 = '0;
    mul1_sel1 = '0;
    mul1_sel2 = '0;
    alu1_op   = 1'b0;
    mul1_op   = 1'b0;
    reg_en    = '0;
    result_en = 1'b0;
    done_next = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = PC_W'(START_PC);
`ifdef HLS_SEQ_HOLD_EN
          hcnt_d  = '0;
`endif
        end
      end
      RUN: begin
        alu1_sel1 = word[ALU1_SEL1_LSB +: SEL_W];
        alu1_sel2 = word[ALU1_SEL2_LSB +: SEL_W];
        alu1_op   = word[ALU1_OP_BIT];
        mul1_sel1 = word[MUL1_SEL1_LSB +: SEL_W];
        mul1_sel2 = word[MUL1_SEL2_LSB +: SEL_W];
        mul1_op   = word[MUL1_OP_BIT];
        reg_en    = word[REG_EN_LSB +: REG_EN_W];
        result_en = word[RESULT_EN_BIT];
        if (hold_more) begin
`ifdef HLS_SEQ_HOLD_EN
          hcnt_d = hcnt_q + HOLD_W'(1);
`endif
        end else begin
`ifdef HLS_SEQ_HOLD_EN
          hcnt_d = '0;
`endif
          if (at_end) begin
            done_next = 1'b1;
            state_d   = IDLE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hls_sequencer.sv
// Self-checking bench for hls_sequencer. A program shadow plus a trace
// model (list of control words per cycle) predicts every RUN cycle.
module tb_hls_sequencer;

  localparam int DEPTH = 16;
  localparam int PC_W  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            prog_we;
  logic [PC_W-1:0] prog_addr;
  logic [31:0]     prog_wdata;
  logic [3:0]      alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2;
  logic            alu1_op, mul1_op;
  logic [6:0]      reg_en;
  logic            result_en;
  logic            done_next;

  int checks = 0;
  int errors = 0;

  logic [31:0] shadow [DEPTH];
  logic [31:0] trace [$];

  hls_sequencer #(
    .DEPTH    (DEPTH),
    .START_PC (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .alu1_sel1  (alu1_sel1),
    .alu1_sel2  (alu1_sel2),
    .mul1_sel1  (mul1_sel1),
    .mul1_sel2  (mul1_sel2),
    .alu1_op    (alu1_op),
    .mul1_op    (mul1_op),
    .reg_en     (reg_en),
    .result_en  (result_en),
    .done_next  (done_next)
  );

  always #5 clk = ~clk;

  // Observed outputs packed in control-word bit order, with busy/done on top
  logic [27:0] obs;
  assign obs = {busy, done_next, result_en, reg_en, mul1_op, mul1_sel2, mul1_sel1,
                alu1_op, alu1_sel2, alu1_sel1};

  // Model: expand the program into one control word per executed cycle
  task automatic build_trace();
    int pc = 0;
    int reps;
    logic [31:0] w;
    trace.delete();
    forever begin
      w = shadow[pc];
`ifdef HLS_SEQ_HOLD_EN
      reps = int'(w[30:28]) + 1;
`else
      reps = 1;
`endif
      for (int r = 0; r < reps; r++) trace.push_back(w);
      if (w[31] || pc == DEPTH - 1) break;
      pc++;
    end
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = addr[PC_W-1:0];
    prog_wdata = data;
    shadow[addr] = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Starts a run at the current negedge and checks each RUN cycle plus the
  // idle cycle after. inject >= 0 pulses start and prog_we in that RUN cycle.
  task automatic run_prog(input string name, input int inject,
                          input bit wr_same, input logic [31:0] wr_data);
    logic [27:0] exp;
    int n;
    if (wr_same) begin
      prog_we      = 1'b1;
      prog_addr    = '0;
      prog_wdata   = wr_data;
      shadow[0]    = wr_data;
    end
    build_trace();
    n = trace.size();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
      exp = {1'b1, (i == n - 1), trace[i][25:0]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, exp);
      end
      if (i == inject) begin
        start      = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = '0;
        prog_wdata = ~shadow[0];
      end
    end
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    checks++;
    if (obs !== 28'h0) begin
      errors++;
      $display("FAIL %s end idle: got %h expected 0", name, obs);
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 28'h0) begin
        errors++;
        $display("FAIL %s idle %0d: got %h expected 0", name, i, obs);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check("reset", 5);
  endtask

  task automatic test_three_words();
    write_word(0, $urandom() & 32'h0FFF_FFFF);
    write_word(1, (32'd0 << 9) | (32'd1 << 13) | (32'h01 << 18));
    write_word(2, ($urandom() & 32'h0FFF_FFFF) | 32'h8000_0000);
    run_prog("three_words", -1, 1'b0, '0);
  endtask

  task automatic test_hold();
    write_word(0, ($urandom() & 32'h0FFF_FFFF) | (32'd3 << 28));
    write_word(1, ($urandom() & 32'h0FFF_FFFF) | 32'h8000_0000);
    run_prog("hold", -1, 1'b0, '0);
  endtask

  task automatic test_no_last();
    for (int a = 0; a < DEPTH; a++) write_word(a, $urandom() & 32'h7FFF_FFFF);
    run_prog("no_last", -1, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        // Sparse last bits give runs of varied length
        write_word(a, ($urandom() & 32'h7FFF_FFFF) |
                      (($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'h0));
      end
      run_prog("random", -1, 1'b0, '0);
    end
  endtask

  task automatic test_write_with_start();
    run_prog("write_with_start", -1, 1'b1, $urandom() & 32'h7FFF_FFFF);
  endtask

  task automatic test_back_to_back();
    write_word(0, $urandom() & 32'h0FFF_FFFF);
    write_word(1, $urandom() & 32'h0FFF_FFFF);
    write_word(2, ($urandom() & 32'h0FFF_FFFF) | 32'h8000_0000);
    run_prog("run_ignores_1", 0, 1'b0, '0);
    // Next run starts one cycle after busy falls; word 0 must be unchanged
    run_prog("run_ignores_2", 1, 1'b0, '0);
    idle_check("no_second_run", 2);
  endtask

  task automatic test_reset_midrun();
    logic [27:0] exp;
    write_word(0, $urandom() & 32'h0FFF_FFFF);
    write_word(1, $urandom() & 32'h0FFF_FFFF);
    write_word(2, ($urandom() & 32'h0FFF_FFFF) | 32'h8000_0000);
    build_trace();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {1'b1, 1'b0, trace[i][25:0]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pre_abort cycle %0d: got %h expected %h", i + 1, obs, exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== 28'h0) begin
      errors++;
      $display("FAIL abort: got %h expected 0", obs);
    end
    run_prog("after_abort", -1, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_three_words();
`ifdef HLS_SEQ_HOLD_EN
    test_hold();
`endif
    test_no_last();
    test_random();
    test_write_with_start();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
